// File: rtl/mmio_console.sv
// Memory-mapped console: watches the CPU mailbox word, queues PUTC characters
// into a small FIFO, and serialises them as UART 8N1; HALT latches an exit code.
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | line high, pop FIFO head when a character waits
// START  | start bit (low) for one bit period
// DATA   | 8 data bits, LSB first, one bit period each
// STOP   | stop bit (high) for one bit period
module mmio_console #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        iwClk,
  input  logic        iwnRst,
  input  logic [31:0] iwLastData,
  output logic        owTx,
  output logic        owBusy,
  output logic        owHalted,
  output logic [7:0]  owExitCode,
  output logic        owOverflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FIFO_FULL   = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [31:0]   rPrev;
  logic [7:0]    rMem [FIFO_DEPTH];
  logic [PW-1:0] rWrPtr;
  logic [PW-1:0] rRdPtr;
  logic [CW-1:0] rCount;
  logic [1:0]    rState;
  logic [BW-1:0] rBaud;
  logic [2:0]    rIdx;
  logic [7:0]    rShift;
  logic          rTx;
  logic          rHalted;
  logic [7:0]    rExit;
  logic          rOverflow;

  logic wEvent;
  logic wPutc;
  logic wHalt;
  logic wEmpty;
  logic wFull;
  logic wPop;
  logic wPush;

  // Commands are edge-triggered on a change of the mailbox word.
  assign wEvent = (iwLastData != rPrev) && !rHalted;
  assign wPutc  = wEvent && (iwLastData[31:24] == 8'h01);
  assign wHalt  = wEvent && (iwLastData[31:24] == 8'hFF);
  assign wEmpty = (rCount == '0);
  assign wFull  = (rCount == FIFO_FULL);
  assign wPop   = (rState == S_IDLE) && !wEmpty;
  assign wPush  = wPutc && (!wFull || wPop);

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      rPrev <= '0;
    end else begin
      rPrev <= iwLastData;
    end
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      rHalted   <= 1'b0;
      rExit     <= '0;
      rOverflow <= 1'b0;
    end else begin
      if (wHalt) begin
        rHalted <= 1'b1;
        rExit   <= iwLastData[7:0];
      end
      if (wPutc && wFull && !wPop) rOverflow <= 1'b1;
    end
  end

  // Storage needs no reset: validity is tracked entirely by rCount.
  always_ff @(posedge iwClk) begin
    if (wPush) rMem[rWrPtr] <= iwLastData[7:0];
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      rWrPtr <= '0;
      rRdPtr <= '0;
      rCount <= '0;
    end else begin
      if (wPush) rWrPtr <= rWrPtr + PW'(1);
      if (wPop)  rRdPtr <= rRdPtr + PW'(1);
      case ({wPush, wPop})
        2'b10:   rCount <= rCount + CW'(1);
        2'b01:   rCount <= rCount - CW'(1);
        default: rCount <= rCount;
      endcase
    end
  end

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      rState <= S_IDLE;
      rBaud  <= '0;
      rIdx   <= '0;
      rShift <= '0;
      rTx    <= 1'b1;
    end else begin
      case (rState)
        S_IDLE: begin
          rTx <= 1'b1;
          if (!wEmpty) begin
            rShift <= rMem[rRdPtr];
            rState <= S_START;
            rBaud  <= BAUD_RELOAD;
            rTx    <= 1'b0;
          end
        end
        S_START: begin
          if (rBaud == '0) begin
            rState <= S_DATA;
            rBaud  <= BAUD_RELOAD;
            rIdx   <= '0;
            rTx    <= rShift[0];
          end else begin
            rBaud <= rBaud - BW'(1);
          end
        end
        S_DATA: begin
          if (rBaud == '0) begin
            rBaud <= BAUD_RELOAD;
            if (rIdx == 3'd7) begin
              rState <= S_STOP;
              rTx    <= 1'b1;
            end else begin
              rIdx <= rIdx + 3'd1;
              rTx  <= rShift[rIdx + 3'd1];
            end
          end else begin
            rBaud <= rBaud - BW'(1);
          end
        end
        S_STOP: begin
          if (rBaud == '0) begin
            rState <= S_IDLE;
          end else begin
            rBaud <= rBaud - BW'(1);
          end
        end
        default: begin
          rState <= S_IDLE;
          rTx    <= 1'b1;
        end
      endcase
    end
  end

  assign owTx       = rTx;
  assign owBusy     = !wEmpty || (rState != S_IDLE);
  assign owHalted   = rHalted;
  assign owExitCode = rExit;
  assign owOverflow = rOverflow;

endmodule
